// File: rtl/mc_fork_unit_pkg.sv
// mc_fork_unit_pkg: shared router constants, direction masks and enums for multicast forking.
// Each travel direction splits the 16-node destination bitmap into four nibble regions.
package mc_fork_unit_pkg;
    localparam int NPORT = 5;
    localparam int DST_W = 16;

    typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} outdir_e;
    typedef enum logic {IDLE, FORK} state_e;

    // Reverse port is always empty; the other ports take nibbles 0..3 in port order.
    localparam logic [DST_W-1:0] N_MASK_N = 16'h000F;
    localparam logic [DST_W-1:0] N_MASK_E = 16'h00F0;
    localparam logic [DST_W-1:0] N_MASK_S = 16'h0000;
    localparam logic [DST_W-1:0] N_MASK_W = 16'h0F00;
    localparam logic [DST_W-1:0] N_MASK_L = 16'hF000;
    localparam logic [DST_W-1:0] E_MASK_N = 16'h000F;
    localparam logic [DST_W-1:0] E_MASK_E = 16'h00F0;
    localparam logic [DST_W-1:0] E_MASK_S = 16'h0F00;
    localparam logic [DST_W-1:0] E_MASK_W = 16'h0000;
    localparam logic [DST_W-1:0] E_MASK_L = 16'hF000;
    localparam logic [DST_W-1:0] S_MASK_N = 16'h0000;
    localparam logic [DST_W-1:0] S_MASK_E = 16'h000F;
    localparam logic [DST_W-1:0] S_MASK_S = 16'h00F0;
    localparam logic [DST_W-1:0] S_MASK_W = 16'h0F00;
    localparam logic [DST_W-1:0] S_MASK_L = 16'hF000;
    localparam logic [DST_W-1:0] W_MASK_N = 16'h000F;
    localparam logic [DST_W-1:0] W_MASK_E = 16'h0000;
    localparam logic [DST_W-1:0] W_MASK_S = 16'h00F0;
    localparam logic [DST_W-1:0] W_MASK_W = 16'h0F00;
    localparam logic [DST_W-1:0] W_MASK_L = 16'hF000;

    localparam logic [3:0][NPORT-1:0][DST_W-1:0] MASKS = {
        {W_MASK_L, W_MASK_W, W_MASK_S, W_MASK_E, W_MASK_N},
        {S_MASK_L, S_MASK_W, S_MASK_S, S_MASK_E, S_MASK_N},
        {E_MASK_L, E_MASK_W, E_MASK_S, E_MASK_E, E_MASK_N},
        {N_MASK_L, N_MASK_W, N_MASK_S, N_MASK_E, N_MASK_N}
    };

    function automatic logic [DST_W-1:0] dir_mask(input outdir_e d, input logic [2:0] p);
        return MASKS[d][p];
    endfunction
endpackage

// File: rtl/mc_dst_split.sv
// mc_dst_split: splits a destination bitmap into per-port pruned lists and the preferred-port vector.
module mc_dst_split
    import mc_fork_unit_pkg::*;
(
    input  logic [DST_W-1:0]       dst_i,
    input  outdir_e                outdir_i,
    output logic [NPORT-1:0]       ppv_o,
    output logic [NPORT*DST_W-1:0] lists_o
);
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign lists_o[p*DST_W +: DST_W] = dst_i & dir_mask(outdir_i, 3'(p));
        assign ppv_o[p] = |lists_o[p*DST_W +: DST_W];
    end
endmodule

// File: rtl/mc_fork_unit.sv
// mc_fork_unit: holds one multicast flit, requests its preferred ports and emits a pruned copy per grant.
module mc_fork_unit
    import mc_fork_unit_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int STARVE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_outdir,
    input  logic [DST_W-1:0]       in_dst_list,
    input  logic [DATA_W-1:0]      in_data,
    output logic [NPORT-1:0]       req_ppv,
    input  logic [NPORT-1:0]       grant,
    output logic                   starve,
    output logic [NPORT-1:0]       out_valid,
    output logic [NPORT*DST_W-1:0] out_dst_list,
    output logic [DATA_W-1:0]      out_data,
    output logic                   drop_empty
);
    state_e                 state_q, state_d;
    logic [NPORT-1:0]       pending_q, pending_d;
    logic [NPORT*DST_W-1:0] lists_q, lists_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [NPORT-1:0]       out_valid_q, out_valid_d;
    logic [NPORT*DST_W-1:0] out_dst_q, out_dst_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [STARVE_W-1:0]    cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic [NPORT-1:0]       ppv, eff, rest;
    logic [NPORT*DST_W-1:0] split_lists;
    logic                   accept;

    mc_dst_split u_split (
        .dst_i   (in_dst_list),
        .outdir_i(outdir_e'(in_outdir)),
        .ppv_o   (ppv),
        .lists_o (split_lists)
    );

    always_comb begin
        eff = (state_q == FORK) ? grant & pending_q : '0;
        rest = pending_q & ~eff;
        in_ready = (state_q == IDLE) || (rest == '0);
        accept = in_valid && in_ready;
        state_d = (state_q == FORK && rest == '0) ? IDLE : state_q;
        pending_d = rest;
        lists_d = lists_q;
        data_d = data_q;
        cnt_d = (state_q == FORK && eff == '0) ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
        drop_d = accept && (ppv == '0);
        // A new flit accepted in the final grant cycle overwrites the hold registers;
        // the old copies are already captured in the output stage below.
        if (accept && ppv != '0) begin
            state_d = FORK;
            pending_d = ppv;
            lists_d = split_lists;
            data_d = in_data;
            cnt_d = '0;
        end
        out_valid_d = eff;
        out_dst_d = '0;
        for (int p = 0; p < NPORT; p++)
            out_dst_d[p*DST_W +: DST_W] = eff[p] ? lists_q[p*DST_W +: DST_W] : '0;
        out_data_d = (eff != '0) ? data_q : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pending_q <= '0;
            lists_q <= '0;
            data_q <= '0;
            out_valid_q <= '0;
            out_dst_q <= '0;
            out_data_q <= '0;
            cnt_q <= '0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            lists_q <= lists_d;
            data_q <= data_d;
            out_valid_q <= out_valid_d;
            out_dst_q <= out_dst_d;
            out_data_q <= out_data_d;
            cnt_q <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign req_ppv = pending_q;
    assign starve = &cnt_q;
    assign out_valid = out_valid_q;
    assign out_dst_list = out_dst_q;
    assign out_data = out_data_q;
    assign drop_empty = drop_q;
endmodule

// File: tb/tb_mc_fork_unit.sv
// tb_mc_fork_unit: directed and random stimulus against a set-based model of the multicast fork unit.
module tb_mc_fork_unit;
    import mc_fork_unit_pkg::*;
    localparam int DW = 128;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic [1:0]             in_outdir = '0;
    logic [DST_W-1:0]       in_dst_list = '0;
    logic [DW-1:0]          in_data = '0;
    logic [NPORT-1:0]       grant = '0;
    logic                   in_ready, starve, drop_empty;
    logic [NPORT-1:0]       req_ppv, out_valid;
    logic [NPORT*DST_W-1:0] out_dst_list;
    logic [DW-1:0]          out_data;

    always #5 clk = ~clk;

    mc_fork_unit #(.DATA_W(DW), .STARVE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_outdir(in_outdir), .in_dst_list(in_dst_list), .in_data(in_data),
        .req_ppv(req_ppv), .grant(grant), .starve(starve), .out_valid(out_valid),
        .out_dst_list(out_dst_list), .out_data(out_data), .drop_empty(drop_empty)
    );

    int total = 0, passed = 0;
    bit busy, e_drop;
    int run;
    logic [NPORT-1:0] pend, e_ov;
    logic [DST_W-1:0] lst[NPORT];
    logic [DW-1:0] dat, e_data;
    logic [NPORT*DST_W-1:0] e_od;

    // Reverse direction gets nothing; remaining ports take successive nibbles in port order.
    function automatic logic [DST_W-1:0] bmask(input int d, input int p);
        int rev = (d + 2) % 4;
        if (p == rev || p >= NPORT) return '0;
        return DST_W'(16'hF << (4 * (p - ((p > rev) ? 1 : 0))));
    endfunction

    task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    endtask

    task automatic model_reset();
        busy = 0; run = 0; pend = '0; dat = '0; e_ov = '0; e_od = '0; e_data = '0; e_drop = 0;
        for (int p = 0; p < NPORT; p++) lst[p] = '0;
    endtask

    task automatic cyc(input bit v, input logic [1:0] d, input logic [DST_W-1:0] dst,
                       input logic [DW-1:0] data, input logic [NPORT-1:0] g);
        logic [NPORT-1:0] req, eff, rest, nppv;
        logic [DST_W-1:0] nl[NPORT];
        bit rdy, acc;
        @(negedge clk);
        in_valid = v; in_outdir = d; in_dst_list = dst; in_data = data; grant = g;
        #1;
        req = busy ? pend : '0;
        eff = g & req;
        rest = req & ~eff;
        rdy = !busy || rest == '0;
        chk("in_ready", DW'(in_ready), DW'(rdy));
        chk("req_ppv", DW'(req_ppv), DW'(req));
        chk("starve", DW'(starve), DW'(run >= 15));
        chk("out_valid", DW'(out_valid), DW'(e_ov));
        chk("out_dst_list", DW'(out_dst_list), DW'(e_od));
        chk("out_data", out_data, e_data);
        chk("drop_empty", DW'(drop_empty), DW'(e_drop));
        acc = v && rdy;
        for (int p = 0; p < NPORT; p++) begin
            nl[p] = dst & bmask(int'(d), p);
            nppv[p] = nl[p] != '0;
        end
        e_ov = eff;
        e_od = '0;
        for (int p = 0; p < NPORT; p++) if (eff[p]) e_od[p*DST_W +: DST_W] = lst[p];
        if (eff != '0) e_data = dat;
        e_drop = acc && nppv == '0;
        if (busy) begin
            if (eff == '0) begin
                if (run < 100) run++;
            end else run = 0;
            pend = rest;
            if (rest == '0) begin busy = 0; run = 0; end
        end
        if (acc && nppv != '0) begin
            busy = 1; pend = nppv; dat = data; run = 0;
            for (int p = 0; p < NPORT; p++) lst[p] = nl[p];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'd0, '0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] d1, d2, d5, d6;
        d1 = {4{32'h1111_0001}}; d2 = {4{32'h2222_0002}}; d5 = {4{32'h5555_0005}}; d6 = {4{32'h6666_0006}};
        model_reset();
        #2;
        chk("rst_req", DW'(req_ppv), '0);
        chk("rst_ov", DW'(out_valid), '0);
        chk("rst_starve", DW'(starve), '0);
        chk("rst_drop", DW'(drop_empty), '0);
        chk("rst_ready", DW'(in_ready), DW'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cyc(1, 2'd0, 16'h3000, d1, '0);
        cyc(0, 2'd0, '0, '0, 5'b10000);
        chk("uni_req", DW'(req_ppv), DW'(5'b10000));
        chk("uni_ready", DW'(in_ready), DW'(1));
        idle(1);
        chk("uni_ov", DW'(out_valid), DW'(5'b10000));
        chk("uni_dst", DW'(out_dst_list[79:64]), DW'(16'h3000));
        chk("uni_data", out_data, d1);

        cyc(1, 2'd0, 16'h0A50, d2, '0);
        cyc(0, 2'd0, '0, '0, 5'b00010);
        chk("split_req", DW'(req_ppv), DW'(5'b01010));
        cyc(0, 2'd0, '0, '0, 5'b01000);
        chk("split_ov1", DW'(out_valid), DW'(5'b00010));
        chk("split_dst1", DW'(out_dst_list[31:16]), DW'(16'h0050));
        idle(1);
        chk("split_ov2", DW'(out_valid), DW'(5'b01000));
        chk("split_dst2", DW'(out_dst_list[63:48]), DW'(16'h0A00));
        chk("split_done", DW'(req_ppv), '0);

        cyc(1, 2'd0, 16'h0011, d5, '0);
        cyc(0, 2'd0, '0, '0, 5'b11100);
        chk("spur_req", DW'(req_ppv), DW'(5'b00011));
        for (int i = 0; i < 14; i++) begin
            cyc(0, 2'd0, '0, '0, '0);
            if (i == 0) chk("spur_ov", DW'(out_valid), '0);
        end
        cyc(0, 2'd0, '0, '0, 5'b00001);
        chk("starve_set", DW'(starve), DW'(1));
        cyc(0, 2'd0, '0, '0, 5'b00010);
        chk("starve_clr", DW'(starve), '0);
        idle(1);

        cyc(1, 2'd2, '0, d6, '0);
        idle(1);
        chk("empty_drop", DW'(drop_empty), DW'(1));
        chk("empty_req", DW'(req_ppv), '0);
        idle(1);
        chk("empty_pulse", DW'(drop_empty), '0);

        cyc(1, 2'd0, 16'h1001, d5, '0);
        cyc(1, 2'd2, 16'h0011, d6, 5'b10001);
        chk("b2b_ready", DW'(in_ready), DW'(1));
        idle(1);
        chk("b2b_ov", DW'(out_valid), DW'(5'b10001));
        chk("b2b_data", out_data, d5);
        chk("b2b_req", DW'(req_ppv), DW'(5'b00110));
        cyc(0, 2'd0, '0, '0, 5'b00110);
        idle(1);
        chk("b2b_data2", out_data, d6);

        cyc(1, 2'd1, 16'h0110, d1, '0);
        idle(1);
        chk("rmf_req", DW'(req_ppv), DW'(5'b00110));
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rmf_req0", DW'(req_ppv), '0);
        chk("rmf_ov0", DW'(out_valid), '0);
        chk("rmf_data0", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 2'd0, '0, '0, 5'b11111);
        idle(1);
        chk("rmf_nocopy", DW'(out_valid), '0);

        for (int i = 0; i < 800; i++) begin
            logic [DST_W-1:0] dst;
            logic [NPORT-1:0] g;
            dst = DST_W'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) dst = '0;
            g = ($urandom_range(0, 2) == 0) ? '0 : NPORT'($urandom);
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), dst,
                {$urandom, $urandom, $urandom, $urandom}, g);
        end
        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
